// File: rtl/dyn_lights_seq_pkg.sv
// rtl/dyn_lights_seq_pkg.sv - shared FSM states, direction constants and default code range
package dyn_lights_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_MIN   = 1;
    localparam int DEF_MAX   = 6;

endpackage

// File: rtl/dyn_lights_seq_step_prescaler.sv
// rtl/dyn_lights_seq_step_prescaler.sv - step tick generator; one tick every DIV enabled cycles
// With DIV==1 there is no counter and tick follows en directly.
module step_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_direct
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign tick     = en & ~clr;
        end else begin : g_count
            localparam int CW = $clog2(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] r_cnt;
            logic          w_last;

            assign w_last = (r_cnt == LAST);
            assign tick   = en & ~clr & w_last;

            // A released button or a load restarts the full DIV-cycle count.
            always_ff @(posedge clk) begin
                if (rst || clr || !en) begin
                    r_cnt <= '0;
                end else if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dyn_lights_seq.sv
// rtl/dyn_lights_seq.sv - colour code sequencer with prescaler, direction, load and wrap pulse
// Optional bounce mode selected by macro DYN_LIGHTS_PINGPONG_EN.
module dyn_lights_seq
    import dyn_lights_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MIN_VAL = DEF_MIN,
    parameter int MAX_VAL = DEF_MAX,
    parameter int DIV     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] colour,
    output logic             wrap
);

    generate
        if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2 ** WIDTH) - 1 && DIV >= 1))
        begin : g_bad_params
            $error("dyn_lights_seq: illegal WIDTH/MIN_VAL/MAX_VAL/DIV combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    state_t           r_state;
    logic [WIDTH-1:0] r_colour;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_next;
    logic             w_tick;
    logic             w_load_ok;

    assign colour    = r_colour;
    assign wrap      = r_wrap;
    assign w_load_ok = (load_val >= MIN_C) && (load_val <= MAX_C);

    step_prescaler #(.DIV(DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (button),
        .clr  (load),
        .tick (w_tick)
    );

`ifdef DYN_LIGHTS_PINGPONG_EN
    logic r_dir;
    logic w_dir_next;
    logic w_unused_dir;
    assign w_unused_dir = dir;

    // Flip direction when the step lands on an end; a code already parked on an end just turns back.
    always_comb begin
        w_next      = r_colour;
        w_wrap_next = 1'b0;
        w_dir_next  = r_dir;
        if (r_dir == DIR_UP) begin
            if (r_colour == MAX_C) begin
                w_next     = r_colour - 1'b1;
                w_dir_next = DIR_DN;
            end else begin
                w_next = r_colour + 1'b1;
                if (r_colour == MAX_C - 1'b1) begin
                    w_wrap_next = 1'b1;
                    w_dir_next  = DIR_DN;
                end
            end
        end else begin
            if (r_colour == MIN_C) begin
                w_next     = r_colour + 1'b1;
                w_dir_next = DIR_UP;
            end else begin
                w_next = r_colour - 1'b1;
                if (r_colour == MIN_C + 1'b1) begin
                    w_wrap_next = 1'b1;
                    w_dir_next  = DIR_UP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir <= DIR_UP;
        end else if (!load && w_tick) begin
            r_dir <= w_dir_next;
        end
    end
`else
    always_comb begin
        w_next      = r_colour;
        w_wrap_next = 1'b0;
        if (dir == DIR_UP) begin
            if (r_colour == MAX_C) begin
                w_next      = MIN_C;
                w_wrap_next = 1'b1;
            end else begin
                w_next = r_colour + 1'b1;
            end
        end else begin
            if (r_colour == MIN_C) begin
                w_next      = MAX_C;
                w_wrap_next = 1'b1;
            end else begin
                w_next = r_colour - 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_colour <= MIN_C;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: if (button)  r_state <= ST_RUN;
                ST_RUN:  if (!button) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (load) begin
                if (w_load_ok) r_colour <= load_val;
            end else if (w_tick) begin
                r_colour <= w_next;
                r_wrap   <= w_wrap_next;
            end
        end
    end

endmodule

// File: tb/tb_dyn_lights_seq.sv
// tb/tb_dyn_lights_seq.sv - scoreboard bench for DIV=1 and DIV=4 sequencer instances
module tb_dyn_lights_seq;

    localparam int MINV = 1;
    localparam int MAXV = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [2:0] col1, col4;
    logic       wrap1, wrap4;

    int total = 0;
    int bad = 0;

    logic [3:0] q[2][$];
    int m_col[2];
    int m_cnt[2];
    int m_dir[2];
    int m_div[2];

    always #5 clk = ~clk;

    dyn_lights_seq u_div1 (
        .clk(clk), .rst(rst), .button(button), .dir(dir), .load(load),
        .load_val(load_val), .colour(col1), .wrap(wrap1)
    );

    dyn_lights_seq #(.DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .button(button), .dir(dir), .load(load),
        .load_val(load_val), .colour(col4), .wrap(wrap4)
    );

    // Reference: what the code does on one rising edge, straight from the sequencing rules.
    function automatic logic [3:0] model_edge(input int k, input logic r, input logic b,
                                              input logic d, input logic l, input int lv);
        int w = 0;
        if (r) begin
            m_col[k] = MINV; m_cnt[k] = 0; m_dir[k] = 0;
        end else if (l) begin
            if (lv >= MINV && lv <= MAXV) m_col[k] = lv;
            m_cnt[k] = 0;
        end else if (!b) begin
            m_cnt[k] = 0;
        end else begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == m_div[k]) begin
                m_cnt[k] = 0;
`ifdef DYN_LIGHTS_PINGPONG_EN
                if (m_dir[k] == 0) begin
                    if (m_col[k] == MAXV) begin m_col[k] = MAXV - 1; m_dir[k] = 1; end
                    else begin
                        m_col[k] = m_col[k] + 1;
                        if (m_col[k] == MAXV) begin w = 1; m_dir[k] = 1; end
                    end
                end else begin
                    if (m_col[k] == MINV) begin m_col[k] = MINV + 1; m_dir[k] = 0; end
                    else begin
                        m_col[k] = m_col[k] - 1;
                        if (m_col[k] == MINV) begin w = 1; m_dir[k] = 0; end
                    end
                end
`else
                if (!d) begin
                    if (m_col[k] == MAXV) begin m_col[k] = MINV; w = 1; end
                    else m_col[k] = m_col[k] + 1;
                end else begin
                    if (m_col[k] == MINV) begin m_col[k] = MAXV; w = 1; end
                    else m_col[k] = m_col[k] - 1;
                end
`endif
            end
        end
        return {w[0], m_col[k][2:0]};
    endfunction

    task automatic drive(input logic r, input logic b, input logic d, input logic l,
                         input logic [2:0] lv);
        @(negedge clk);
        rst = r; button = b; dir = d; load = l; load_val = lv;
        for (int k = 0; k < 2; k++) q[k].push_back(model_edge(k, r, b, d, l, int'(lv)));
    endtask

    always @(posedge clk) begin
        logic [3:0] exp_v;
        #1;
        if (q[0].size() > 0) begin
            exp_v = q[0].pop_front();
            total++;
            if ({wrap1, col1} !== exp_v) begin
                bad++;
                $display("FAIL div1 t=%0t got colour=%0d wrap=%0b want colour=%0d wrap=%0b",
                         $time, col1, wrap1, exp_v[2:0], exp_v[3]);
            end
        end
        if (q[1].size() > 0) begin
            exp_v = q[1].pop_front();
            total++;
            if ({wrap4, col4} !== exp_v) begin
                bad++;
                $display("FAIL div4 t=%0t got colour=%0d wrap=%0b want colour=%0d wrap=%0b",
                         $time, col4, wrap4, exp_v[2:0], exp_v[3]);
            end
        end
    end

    initial begin
        m_div[0] = 1; m_div[1] = 4;
        for (int k = 0; k < 2; k++) begin m_col[k] = MINV; m_cnt[k] = 0; m_dir[k] = 0; end

        drive(1, 0, 0, 0, 0);
        repeat (10) drive(0, 1, 0, 0, 0);
        repeat (2)  drive(0, 0, 0, 0, 0);
        repeat (3)  drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        repeat (3)  drive(0, 1, 1, 0, 0);
        repeat (3)  drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (12) drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (5)  drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (5)  drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 3'd5);
        drive(0, 0, 0, 1, 3'd7);
        drive(0, 0, 0, 1, 3'd0);
        drive(1, 0, 0, 1, 3'd5);
        drive(0, 1, 0, 1, 3'd4);
        repeat (3)  drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 3'd6);
        repeat (4)  drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 3'd1);
        repeat (3)  drive(0, 1, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0) ? ~dir : dir,
                  ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
        end

        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL drain inst=%0d got pending=%0d want pending=0", k, q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
